decode_issue_sequencer: RTL and testbench

- Sequencing controller between the instruction queue and the decode/rename stage.
- Splits two-uop operations (MULT/MULTU/DIV/DIVU/MADD/MADDU/MSUB/MSUBU/MUL) into first and second uops, driving the is_inst2 input of the decoder.
- Serializes privileged operations (CACHE/TLBP/TLBR/TLBWI/TLBWR/ERET): waits for the backend to drain, issues the op alone, then blocks until it commits.
- Registered output, valid/ready handshake on both sides.

---
 rtl/decode_issue_sequencer.sv | 131 +++++++++++++
 tb/tb_decode_issue_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_issue_sequencer.sv
// Issue sequencer between the instruction queue and decode/rename: splits
// two-uop ops into first/second halves and serializes privileged ops.
module decode_issue_sequencer #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_two_uop,
  input  logic              in_serial,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_is_inst2,
  output logic              out_serial,
  input  logic              rob_empty,
  input  logic              serial_commit,
  output logic              busy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [1:0]        state_dbg
);

  // Handshake: a transfer happens on a rising clk edge where valid && ready.
  // The output side holds out_valid/out_data stable until out_ready is seen.
  typedef enum logic [1:0] {
    RUN         = 2'd0,
    SECOND      = 2'd1,
    DRAIN       = 2'd2,
    SERIAL_WAIT = 2'd3
  } state_t;

  state_t            state, state_n;
  logic [DATA_W-1:0] hold;
  logic [DATA_W-1:0] load_data;
  logic              adv, accept;
  logic              load, load_inst2, load_serial, hold_load;

  assign adv       = !out_valid || out_ready;
  assign in_ready  = (state == RUN) && adv && !flush;
  assign accept    = in_valid && in_ready;
  assign busy      = (state != RUN);
  assign state_dbg = state;

  always_comb begin
    state_n     = state;
    load        = 1'b0;
    load_data   = hold;
    load_inst2  = 1'b0;
    load_serial = 1'b0;
    hold_load   = 1'b0;
    case (state)
      RUN: begin
        if (accept) begin
          if (in_serial) begin
            // Serial op parks in hold; it issues only once the backend drains.
            hold_load = 1'b1;
            state_n   = DRAIN;
          end else if (in_two_uop) begin
            load      = 1'b1;
            load_data = in_data;
            hold_load = 1'b1;
            state_n   = SECOND;
          end else begin
            load      = 1'b1;
            load_data = in_data;
          end
        end
      end
      SECOND: begin
        if (adv) begin
          load       = 1'b1;
          load_inst2 = 1'b1;
          state_n    = RUN;
        end
      end
      DRAIN: begin
        if (adv && rob_empty) begin
          load        = 1'b1;
          load_serial = 1'b1;
          state_n     = SERIAL_WAIT;
        end
      end
      SERIAL_WAIT: begin
        if (serial_commit) state_n = RUN;
      end
      default: state_n = RUN;
    endcase
    if (flush) state_n = RUN;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= RUN;
    else         state <= state_n;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_is_inst2 <= 1'b0;
      out_serial   <= 1'b0;
    end else if (flush) begin
      out_valid    <= 1'b0;
      out_is_inst2 <= 1'b0;
      out_serial   <= 1'b0;
    end else if (adv) begin
      out_valid    <= load;
      out_is_inst2 <= load && load_inst2;
      out_serial   <= load && load_serial;
      if (load) out_data <= load_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)        hold <= '0;
    else if (hold_load) hold <= in_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cnt <= '0;
    end else if ((state == DRAIN || state == SERIAL_WAIT) && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_decode_issue_sequencer.sv
// Bench for decode_issue_sequencer: directed vector table, async reset case,
// then random traffic checked against an expected-uop queue.
module tb_decode_issue_sequencer;

  logic        clk;
  logic        resetn;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        in_two_uop;
  logic        in_serial;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_is_inst2;
  logic        out_serial;
  logic        rob_empty;
  logic        serial_commit;
  logic        busy;
  logic [31:0] stall_cnt;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  decode_issue_sequencer #(.DATA_W(64), .CNT_W(32)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_two_uop(in_two_uop), .in_serial(in_serial),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_is_inst2(out_is_inst2), .out_serial(out_serial),
    .rob_empty(rob_empty), .serial_commit(serial_commit),
    .busy(busy), .stall_cnt(stall_cnt), .state_dbg(state_dbg)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Vector record: in_bits = {valid,two,serial,out_ready,rob_empty,commit,flush},
  // out_bits = {out_valid,is_inst2,serial,in_ready,busy}.
  typedef struct {
    logic [6:0]  in_bits;
    logic [63:0] d;
    logic [4:0]  out_bits;
    logic [63:0] od;
    logic [31:0] stall;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t vec(input logic [6:0] ib, input logic [63:0] d,
                               input logic [4:0] ob, input logic [63:0] od,
                               input logic [31:0] st);
    vec_t v;
    v.in_bits = ib; v.d = d; v.out_bits = ob; v.od = od; v.stall = st;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver
  task automatic drive(input logic [6:0] ib, input logic [63:0] d);
    {in_valid, in_two_uop, in_serial, out_ready, rob_empty, serial_commit, flush} = ib;
    in_data = d;
  endtask

  // Scoreboard: {serial, inst2, data}
  logic [65:0] exp_q[$];
  logic        prev_stall;
  logic [63:0] prev_data;

  task automatic sb_cycle();
    logic [65:0] e;
    if (prev_stall) begin
      chk("stable_valid", 128'(out_valid), 128'(1'b1));
      chk("stable_data", 128'(out_data), 128'(prev_data));
    end
    if (flush) chk("flush_in_ready", 128'(in_ready), 128'(1'b0));
    if (out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_uop: got %0h with empty expected queue", out_data);
      end else begin
        e = exp_q.pop_front();
        if ({out_serial, out_is_inst2, out_data} !== e) begin
          errors++;
          $display("FAIL uop: got %0h expected %0h", {out_serial, out_is_inst2, out_data}, e);
        end
      end
    end
    if (flush) begin
      exp_q.delete();
    end else if (in_valid && in_ready) begin
      if (in_serial) begin
        exp_q.push_back({1'b1, 1'b0, in_data});
      end else if (in_two_uop) begin
        exp_q.push_back({1'b0, 1'b0, in_data});
        exp_q.push_back({1'b0, 1'b1, in_data});
      end else begin
        exp_q.push_back({1'b0, 1'b0, in_data});
      end
    end
    prev_stall = out_valid && !out_ready && !flush;
    prev_data  = out_data;
  endtask

  initial begin
    vec_t r;
    logic [31:0] n_rand;
    resetn = 1'b0;
    drive(7'b0, 64'h0);
    prev_stall = 1'b0;
    prev_data  = '0;

    // Plain back-to-back
    tbl.push_back(vec(7'b1001000, 64'h11, 5'b00010, 64'h0,  32'd0));
    tbl.push_back(vec(7'b1001000, 64'h22, 5'b10010, 64'h11, 32'd0));
    tbl.push_back(vec(7'b0001000, 64'h0,  5'b10010, 64'h22, 32'd0));
    tbl.push_back(vec(7'b0001000, 64'h0,  5'b00010, 64'h22, 32'd0));
    // Two-uop then plain
    tbl.push_back(vec(7'b1101000, 64'h33, 5'b00010, 64'h22, 32'd0));
    tbl.push_back(vec(7'b1001000, 64'h44, 5'b10001, 64'h33, 32'd0));
    tbl.push_back(vec(7'b1001000, 64'h44, 5'b11010, 64'h33, 32'd0));
    tbl.push_back(vec(7'b0001000, 64'h0,  5'b10010, 64'h44, 32'd0));
    tbl.push_back(vec(7'b0001000, 64'h0,  5'b00010, 64'h44, 32'd0));
    // Serial op with slow drain
    tbl.push_back(vec(7'b1011000, 64'h55, 5'b00010, 64'h44, 32'd0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(vec(7'b0001000, 64'h0, 5'b00001, 64'h44, 32'(i)));
    tbl.push_back(vec(7'b0001100, 64'h0,  5'b00001, 64'h44, 32'd4));
    tbl.push_back(vec(7'b0001100, 64'h0,  5'b10101, 64'h55, 32'd5));
    tbl.push_back(vec(7'b0001110, 64'h0,  5'b00001, 64'h55, 32'd6));
    // Backpressure
    tbl.push_back(vec(7'b1000000, 64'h66, 5'b00010, 64'h55, 32'd7));
    for (int i = 0; i < 3; i++)
      tbl.push_back(vec(7'b1000000, 64'h67, 5'b10000, 64'h66, 32'd7));
    tbl.push_back(vec(7'b1001000, 64'h67, 5'b10010, 64'h66, 32'd7));
    tbl.push_back(vec(7'b0001000, 64'h0,  5'b10010, 64'h67, 32'd7));
    tbl.push_back(vec(7'b0001000, 64'h0,  5'b00010, 64'h67, 32'd7));
    // Flush while the second uop is pending
    tbl.push_back(vec(7'b1101000, 64'h77, 5'b00010, 64'h67, 32'd7));
    tbl.push_back(vec(7'b0001001, 64'h0,  5'b10001, 64'h77, 32'd7));
    tbl.push_back(vec(7'b1001000, 64'h88, 5'b00010, 64'h77, 32'd7));
    tbl.push_back(vec(7'b0001000, 64'h0,  5'b10010, 64'h88, 32'd7));
    tbl.push_back(vec(7'b0001000, 64'h0,  5'b00010, 64'h88, 32'd7));
    // Flush in RUN blocks acceptance
    tbl.push_back(vec(7'b1001001, 64'h99, 5'b00000, 64'h88, 32'd7));
    tbl.push_back(vec(7'b0001000, 64'h0,  5'b00010, 64'h88, 32'd7));
    // two+serial with rob already empty; commit on the handshake cycle
    tbl.push_back(vec(7'b1111100, 64'hAA, 5'b00010, 64'h88, 32'd7));
    tbl.push_back(vec(7'b0001100, 64'h0,  5'b00001, 64'h88, 32'd7));
    tbl.push_back(vec(7'b0001110, 64'h0,  5'b10101, 64'hAA, 32'd8));
    tbl.push_back(vec(7'b0001000, 64'h0,  5'b00010, 64'hAA, 32'd9));

    repeat (3) @(negedge clk);
    chk("reset_out_valid", 128'(out_valid), 128'(1'b0));
    chk("reset_busy", 128'(busy), 128'(1'b0));
    chk("reset_stall", 128'(stall_cnt), 128'(32'd0));
    chk("reset_out_data", 128'(out_data), 128'(64'h0));
    resetn = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      r = tbl[i];
      @(negedge clk);
      drive(r.in_bits, r.d);
      #1;
      chk($sformatf("v%0d_out_valid", i), 128'(out_valid), 128'(r.out_bits[4]));
      chk($sformatf("v%0d_out_data", i),  128'(out_data),  128'(r.od));
      chk($sformatf("v%0d_in_ready", i),  128'(in_ready),  128'(r.out_bits[1]));
      chk($sformatf("v%0d_busy", i),      128'(busy),      128'(r.out_bits[0]));
      chk($sformatf("v%0d_stall", i),     128'(stall_cnt), 128'(r.stall));
      if (r.out_bits[4]) begin
        chk($sformatf("v%0d_inst2", i),  128'(out_is_inst2), 128'(r.out_bits[3]));
        chk($sformatf("v%0d_serial", i), 128'(out_serial),   128'(r.out_bits[2]));
      end
    end

    // Async reset in SERIAL_WAIT
    @(negedge clk);
    drive(7'b1010100, 64'hBB);
    @(negedge clk);
    drive(7'b0000100, 64'h0);
    @(negedge clk);
    #1;
    chk("sw_out_valid", 128'(out_valid), 128'(1'b1));
    chk("sw_busy", 128'(busy), 128'(1'b1));
    #1 resetn = 1'b0;
    #1;
    chk("async_out_valid", 128'(out_valid), 128'(1'b0));
    chk("async_busy", 128'(busy), 128'(1'b0));
    chk("async_stall", 128'(stall_cnt), 128'(32'd0));
    drive(7'b0, 64'h0);
    @(negedge clk);
    resetn = 1'b1;

    // Random traffic against the uop scoreboard
    n_rand = 3000;
    for (int c = 0; c < int'(n_rand); c++) begin
      @(negedge clk);
      in_valid      = ($urandom_range(0, 3) != 0);
      in_data       = {$urandom, $urandom};
      in_two_uop    = ($urandom_range(0, 3) == 0);
      in_serial     = ($urandom_range(0, 7) == 0);
      out_ready     = ($urandom_range(0, 3) != 0);
      rob_empty     = ($urandom_range(0, 2) != 0);
      serial_commit = ($urandom_range(0, 5) == 0);
      flush         = ($urandom_range(0, 29) == 0);
      #1;
      sb_cycle();
    end

    // Drain remaining expected uops
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      drive(7'b0001110, 64'h0);
      #1;
      sb_cycle();
      if (exp_q.size() == 0 && !busy && !out_valid) break;
    end
    chk("drain_queue_empty", 128'(exp_q.size()), 128'(0));
    chk("drain_idle", 128'(busy), 128'(1'b0));
    chk("drain_out_valid", 128'(out_valid), 128'(1'b0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
